// File: rtl/z80_idx_alu_seq.sv
// z80_idx_alu_seq
// Execution sequencer for the indexed ALU group op A,(IX/IY+d)
// (DD/FD 10ooo110 d). It issues three opcode fetches and one operand
// read, computes the A and F results, and publishes a z80fi trace record.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                begin one instruction (sampled in IDLE only)
//   reg_*_in             architectural registers, captured on start
//   bus_rd/addr/ack/rdata  read-only memory bus (held request, ack handshake)
//   busy, done, illegal  status; done pulses for one cycle, illegal qualifies it
//   reg_*_out            results, held from DONE until the next DONE or reset
//   z80fi_*              trace record for the formal instruction spec
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start
// F0    | fetch prefix byte at IP
// F1    | fetch op byte at IP+1
// F2    | fetch displacement d at IP+2
// CALC  | address computation, CALC_CYCLES bus-idle cycles
// MEM   | read operand at (IX|IY)+d
// EXEC  | ALU evaluation, register results into the outputs
// DONE  | one-cycle completion pulse
module z80_idx_alu_seq #(
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] reg_ip_in,
  input  logic [15:0] reg_ix_in,
  input  logic [15:0] reg_iy_in,
  input  logic [7:0]  reg_a_in,
  input  logic [7:0]  reg_f_in,
  output logic        bus_rd,
  output logic [15:0] bus_addr,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [7:0]  reg_a_out,
  output logic [7:0]  reg_f_out,
  output logic [15:0] reg_ip_out,
  output logic        z80fi_valid,
  output logic [23:0] z80fi_insn,
  output logic [3:0]  z80fi_insn_len,
  output logic [15:0] z80fi_bus_raddr,
  output logic [7:0]  z80fi_bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_CALC, S_MEM, S_EXEC, S_DONE
  } state_t;

  localparam logic [3:0] CALC_LOAD = 4'(CALC_CYCLES - 1);

  state_t      state, state_nx;
  logic [15:0] ip_q, ix_q, iy_q;
  logic [7:0]  a_q, f_q;
  logic [7:0]  prefix_q, op_q, d_q, opnd_q;
  logic [3:0]  calc_cnt;
  logic        illegal_q;

  logic        prefix_ok, op_ok, illegal_hit;
  logic [15:0] mem_addr;

  assign prefix_ok = (bus_rdata == 8'hDD) || (bus_rdata == 8'hFD);
  assign op_ok     = (bus_rdata[7:6] == 2'b10) && (bus_rdata[2:0] == 3'b110);
  // Bit 5 of the prefix separates DD (IX) from FD (IY).
  assign mem_addr  = (prefix_q[5] ? iy_q : ix_q) + {{8{d_q[7]}}, d_q};

  assign illegal_hit = bus_ack &&
                       (((state == S_F0) && !prefix_ok) ||
                        ((state == S_F1) && !op_ok));

  // ---------------- ALU ----------------
  logic [2:0] alu_op;
  logic       is_sub, is_logic, cin, c0;
  logic [7:0] b_op, res, alu_a, alu_f;
  logic [8:0] sum;
  logic [4:0] hsum;
  logic       ovf, flag_h, flag_v, flag_c;

  always_comb begin
    alu_op   = op_q[5:3];
    is_sub   = (alu_op == 3'd2) || (alu_op == 3'd3) || (alu_op == 3'd7);
    is_logic = (alu_op == 3'd4) || (alu_op == 3'd5) || (alu_op == 3'd6);
    cin      = ((alu_op == 3'd1) || (alu_op == 3'd3)) ? f_q[0] : 1'b0;
    // Subtraction as A + ~operand + ~carry_in.
    b_op     = is_sub ? ~opnd_q : opnd_q;
    c0       = is_sub ? ~cin : cin;
    sum      = {1'b0, a_q} + {1'b0, b_op} + {8'b0, c0};
    hsum     = {1'b0, a_q[3:0]} + {1'b0, b_op[3:0]} + {4'b0, c0};
    ovf      = (a_q[7] == b_op[7]) && (sum[7] != a_q[7]);
    case (alu_op)
      3'd4:    res = a_q & opnd_q;
      3'd5:    res = a_q ^ opnd_q;
      3'd6:    res = a_q | opnd_q;
      default: res = sum[7:0];
    endcase
    // For subtract ops H and C report borrow, i.e. the inverted adder carry.
    if (alu_op == 3'd4)  flag_h = 1'b1;
    else if (is_logic)   flag_h = 1'b0;
    else                 flag_h = is_sub ? ~hsum[4] : hsum[4];
    flag_v = is_logic ? ~^res : ovf;
    if (is_logic)        flag_c = 1'b0;
    else                 flag_c = is_sub ? ~sum[8] : sum[8];
    alu_f = {res[7], (res == 8'h00), f_q[5], flag_h, f_q[3], flag_v, is_sub, flag_c};
    alu_a = (alu_op == 3'd7) ? a_q : res;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus_rd   = 1'b0;
    bus_addr = 16'h0000;
    case (state)
      S_IDLE: if (start) state_nx = S_F0;
      S_F0: begin
        bus_rd   = 1'b1;
        bus_addr = ip_q;
        if (bus_ack) state_nx = prefix_ok ? S_F1 : S_DONE;
      end
      S_F1: begin
        bus_rd   = 1'b1;
        bus_addr = ip_q + 16'd1;
        if (bus_ack) state_nx = op_ok ? S_F2 : S_DONE;
      end
      S_F2: begin
        bus_rd   = 1'b1;
        bus_addr = ip_q + 16'd2;
        if (bus_ack) state_nx = S_CALC;
      end
      S_CALC: if (calc_cnt == 4'd0) state_nx = S_MEM;
      S_MEM: begin
        bus_rd   = 1'b1;
        bus_addr = mem_addr;
        if (bus_ack) state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_q            <= '0;
      ix_q            <= '0;
      iy_q            <= '0;
      a_q             <= '0;
      f_q             <= '0;
      prefix_q        <= '0;
      op_q            <= '0;
      d_q             <= '0;
      opnd_q          <= '0;
      calc_cnt        <= '0;
      illegal_q       <= 1'b0;
      reg_a_out       <= '0;
      reg_f_out       <= '0;
      reg_ip_out      <= '0;
      z80fi_insn      <= '0;
      z80fi_insn_len  <= '0;
      z80fi_bus_raddr <= '0;
      z80fi_bus_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ip_q <= reg_ip_in;
          ix_q <= reg_ix_in;
          iy_q <= reg_iy_in;
          a_q  <= reg_a_in;
          f_q  <= reg_f_in;
        end
        S_F0: if (bus_ack) prefix_q <= bus_rdata;
        S_F1: if (bus_ack) op_q <= bus_rdata;
        S_F2: if (bus_ack) begin
          d_q      <= bus_rdata;
          calc_cnt <= CALC_LOAD;
        end
        S_CALC: if (calc_cnt != 4'd0) calc_cnt <= calc_cnt - 4'd1;
        S_MEM: if (bus_ack) opnd_q <= bus_rdata;
        S_EXEC: begin
          illegal_q       <= 1'b0;
          reg_a_out       <= alu_a;
          reg_f_out       <= alu_f;
          reg_ip_out      <= ip_q + 16'd3;
          z80fi_insn      <= {d_q, op_q, prefix_q};
          z80fi_insn_len  <= 4'd3;
          z80fi_bus_raddr <= mem_addr;
          z80fi_bus_rdata <= opnd_q;
        end
        default: ;
      endcase
      // Undecodable bytes finish with the architectural state untouched.
      if (illegal_hit) begin
        illegal_q  <= 1'b1;
        reg_a_out  <= a_q;
        reg_f_out  <= f_q;
        reg_ip_out <= ip_q;
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign illegal     = illegal_q;
  assign z80fi_valid = done & ~illegal_q;

endmodule

// File: tb/tb_z80_idx_alu_seq.sv
module tb_z80_idx_alu_seq;

  localparam int CALC = 1;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] reg_ip_in, reg_ix_in, reg_iy_in;
  logic [7:0]  reg_a_in, reg_f_in;
  logic        bus_rd, bus_ack;
  logic [15:0] bus_addr;
  logic [7:0]  bus_rdata;
  logic        busy, done, illegal, z80fi_valid;
  logic [7:0]  reg_a_out, reg_f_out, z80fi_bus_rdata;
  logic [15:0] reg_ip_out, z80fi_bus_raddr;
  logic [23:0] z80fi_insn;
  logic [3:0]  z80fi_insn_len;

  z80_idx_alu_seq #(.CALC_CYCLES(CALC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .reg_ip_in(reg_ip_in), .reg_ix_in(reg_ix_in), .reg_iy_in(reg_iy_in),
    .reg_a_in(reg_a_in), .reg_f_in(reg_f_in),
    .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .busy(busy), .done(done), .illegal(illegal),
    .reg_a_out(reg_a_out), .reg_f_out(reg_f_out), .reg_ip_out(reg_ip_out),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_rdata(z80fi_bus_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  int          total = 0;
  int          bad = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic [15:0] hold_addr = 16'h0;
  logic [15:0] rd_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: decides ack/data away from the sampling edge.
  always @(negedge clk) begin
    if (bus_rd === 1'b1) begin
      if (wcnt == 0) hold_addr = bus_addr;
      else chk("addr_stable", {16'h0, bus_addr}, {16'h0, hold_addr});
      if (wcnt < wait_n) begin
        bus_ack = 1'b0;
        wcnt++;
      end else begin
        bus_ack   = 1'b1;
        bus_rdata = mem[bus_addr];
        rd_log.push_back(bus_addr);
        wcnt = 0;
      end
    end else begin
      bus_ack   = ($urandom_range(0, 3) == 0);
      bus_rdata = 8'($urandom);
      wcnt = 0;
    end
  end

  function automatic int sgn8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic logic [15:0] op_addr(input logic [7:0] p, input logic [15:0] ix,
                                          input logic [15:0] iy, input logic [7:0] d);
    int base;
    base = (p == 8'hFD) ? int'(iy) : int'(ix);
    return 16'((base + sgn8(int'(d))) & 32'hFFFF);
  endfunction

  task automatic place(input logic [15:0] ip, input logic [7:0] b0, b1, b2);
    mem[ip]          = b0;
    mem[ip + 16'd1]  = b1;
    mem[ip + 16'd2]  = b2;
  endtask

  task automatic run_insn(input logic [15:0] ip, ix, iy, input logic [7:0] a, f,
                          input int w, input bit poke_busy);
    logic [7:0]  p, o, dd, opnd, r8, fexp, aexp;
    logic [15:0] addr, ipo;
    logic [15:0] exp_rd[$];
    bit          lp, lo, cy, hc, v, n;
    int          kind, ai, bi, ci, r, sr, hr, exp_cyc, cyc;

    // reference model
    p  = mem[ip];
    o  = mem[ip + 16'd1];
    dd = mem[ip + 16'd2];
    lp = (p == 8'hDD) || (p == 8'hFD);
    kind = -1;
    for (int i = 0; i < 8; i++) if (o == 8'(8'h86 + 8 * i)) kind = i;
    lo = (kind >= 0);
    addr = op_addr(p, ix, iy, dd);
    opnd = mem[addr];
    exp_rd.push_back(ip);
    if (lp) exp_rd.push_back(ip + 16'd1);
    if (lp && lo) begin
      exp_rd.push_back(ip + 16'd2);
      exp_rd.push_back(addr);
    end
    aexp = a; fexp = f; ipo = ip;
    if (!lp)      exp_cyc = (1 + w) + 1;
    else if (!lo) exp_cyc = 2 * (1 + w) + 1;
    else begin
      exp_cyc = 4 * (1 + w) + CALC + 2;
      ai = int'(a); bi = int'(opnd);
      ci = (kind == 1 || kind == 3) ? int'(f[0]) : 0;
      n = 0; cy = 0; hc = 0; v = 0; r = 0;
      case (kind)
        0, 1: begin
          r  = ai + bi + ci;
          cy = (r > 255);
          hc = ((ai % 16) + (bi % 16) + ci) > 15;
          sr = sgn8(ai) + sgn8(bi) + ci;
          v  = (sr > 127) || (sr < -128);
        end
        2, 3, 7: begin
          r  = ai - bi - ci;
          cy = (r < 0);
          hr = (ai % 16) - (bi % 16) - ci;
          hc = (hr < 0);
          sr = sgn8(ai) - sgn8(bi) - ci;
          v  = (sr > 127) || (sr < -128);
          n  = 1;
        end
        default: begin
          if (kind == 4) r = ai & bi;
          else if (kind == 5) r = ai ^ bi;
          else r = ai | bi;
          hc = (kind == 4);
          v  = ($countones(8'(r)) % 2) == 0;
        end
      endcase
      r8   = 8'(r & 255);
      fexp = {r8[7], r8 == 8'h00, f[5], hc, f[3], v, n, cy};
      aexp = (kind == 7) ? a : r8;
      ipo  = ip + 16'd3;
    end

    // stimulus
    @(negedge clk);
    reg_ip_in = ip; reg_ix_in = ix; reg_iy_in = iy; reg_a_in = a; reg_f_in = f;
    wait_n = w;
    rd_log.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reg_ip_in = 16'($urandom); reg_ix_in = 16'($urandom); reg_iy_in = 16'($urandom);
    reg_a_in = 8'($urandom); reg_f_in = 8'($urandom);
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      cyc = k;
      if (done) break;
      start = (poke_busy && k == 2);
    end
    start = 1'b0;
    chk("done_seen", {31'b0, done}, 32'd1);
    chk("latency", cyc, exp_cyc);
    chk("illegal", {31'b0, illegal}, {31'b0, !(lp && lo)});
    chk("z80fi_valid", {31'b0, z80fi_valid}, {31'b0, lp && lo});
    chk("a_out", {24'b0, reg_a_out}, {24'b0, aexp});
    chk("f_out", {24'b0, reg_f_out}, {24'b0, fexp});
    chk("ip_out", {16'b0, reg_ip_out}, {16'b0, ipo});
    if (lp && lo) begin
      chk("insn", {8'b0, z80fi_insn}, {8'b0, dd, o, p});
      chk("insn_len", {28'b0, z80fi_insn_len}, 32'd3);
      chk("raddr", {16'b0, z80fi_bus_raddr}, {16'b0, addr});
      chk("rdata", {24'b0, z80fi_bus_rdata}, {24'b0, opnd});
    end
    chk("n_reads", rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      chk("read_addr", {16'b0, rd_log[i]}, {16'b0, exp_rd[i]});
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("idle_after", {31'b0, busy}, 32'd0);
    chk("valid_one_cycle", {31'b0, z80fi_valid}, 32'd0);
  endtask

  initial begin
    int dcount, k;
    logic [7:0]  p, o, d;
    logic [15:0] ip, ix, iy;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h00;
    reg_ip_in = '0; reg_ix_in = '0; reg_iy_in = '0; reg_a_in = '0; reg_f_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_rd", {31'b0, bus_rd}, 32'd0);
    chk("rst_bus_addr", {16'b0, bus_addr}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_valid", {31'b0, z80fi_valid}, 32'd0);
    chk("rst_outs", {reg_a_out, reg_f_out, reg_ip_out}, 32'd0);
    chk("rst_fi", {z80fi_insn, z80fi_insn_len, 4'b0}, 32'd0);
    chk("rst_fi_bus", {z80fi_bus_raddr, z80fi_bus_rdata, 8'b0}, 32'd0);
    reset = 1'b0;

    // ADD A,(IX+5)
    place(16'h0100, 8'hDD, 8'h86, 8'h05); mem[16'h1005] = 8'h3C;
    run_insn(16'h0100, 16'h1000, 16'h5555, 8'h44, 8'h00, 0, 0);
    chk("t_add_a", {24'b0, reg_a_out}, 32'h80);
    chk("t_add_f", {24'b0, reg_f_out}, 32'h94);
    chk("t_add_ip", {16'b0, reg_ip_out}, 32'h0103);
    // SUB A,(IY-2)
    place(16'h0200, 8'hFD, 8'h96, 8'hFE); mem[16'h2000] = 8'h20;
    run_insn(16'h0200, 16'h7777, 16'h2002, 8'h10, 8'h00, 0, 0);
    chk("t_sub_a", {24'b0, reg_a_out}, 32'hF0);
    chk("t_sub_f", {24'b0, reg_f_out}, 32'h83);
    chk("t_sub_addr", {16'b0, z80fi_bus_raddr}, 32'h2000);
    // CP
    place(16'h0300, 8'hDD, 8'hBE, 8'h00); mem[16'h3000] = 8'h05;
    run_insn(16'h0300, 16'h3000, 16'h0000, 8'h05, 8'h28, 0, 0);
    chk("t_cp_a", {24'b0, reg_a_out}, 32'h05);
    chk("t_cp_f", {24'b0, reg_f_out}, 32'h6A);
    // XOR
    place(16'h0400, 8'hDD, 8'hAE, 8'h00); mem[16'h3100] = 8'hFF;
    run_insn(16'h0400, 16'h3100, 16'h0000, 8'hFF, 8'h00, 0, 0);
    chk("t_xor_a", {24'b0, reg_a_out}, 32'h00);
    chk("t_xor_f", {24'b0, reg_f_out}, 32'h44);
    // SBC with carry in
    place(16'h0500, 8'hDD, 8'h9E, 8'h00); mem[16'h3200] = 8'h00;
    run_insn(16'h0500, 16'h3200, 16'h0000, 8'h00, 8'h01, 0, 0);
    chk("t_sbc_a", {24'b0, reg_a_out}, 32'hFF);
    chk("t_sbc_f", {24'b0, reg_f_out}, 32'h93);
    // operand address wraps
    place(16'h0600, 8'hDD, 8'h86, 8'h01); mem[16'h0000] = 8'h11;
    run_insn(16'h0600, 16'hFFFF, 16'h0000, 8'h22, 8'h00, 0, 0);
    chk("t_wrap_addr", {16'b0, z80fi_bus_raddr}, 32'h0000);
    // fetch addresses wrap
    place(16'hFFFF, 8'hFD, 8'h8E, 8'h10); mem[16'h4010] = 8'h7F;
    run_insn(16'hFFFF, 16'h0000, 16'h4000, 8'h01, 8'h01, 0, 0);
    chk("t_ipwrap", {16'b0, reg_ip_out}, 32'h0002);
    // 3 wait cycles per read, start pulsed while busy
    place(16'h0700, 8'hFD, 8'hA6, 8'h80); mem[16'h4F80] = 8'h0F;
    run_insn(16'h0700, 16'h0000, 16'h5000, 8'h3C, 8'h00, 3, 1);
    // illegal prefix / op
    place(16'h0800, 8'hED, 8'h86, 8'h00);
    run_insn(16'h0800, 16'h1234, 16'h4321, 8'h5A, 8'hA5, 0, 1);
    place(16'h0900, 8'hDD, 8'h87, 8'h00);
    run_insn(16'h0900, 16'h1234, 16'h4321, 8'h5B, 8'hC3, 1, 0);

    // reset asserted while in MEM
    place(16'h0A00, 8'hDD, 8'h86, 8'h04); mem[16'h6004] = 8'h01;
    @(negedge clk);
    reg_ip_in = 16'h0A00; reg_ix_in = 16'h6000; reg_iy_in = 16'h0; reg_a_in = 8'h10; reg_f_in = 8'h0;
    wait_n = 4; rd_log.delete(); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (!(rd_log.size() == 3 && bus_rd && !dut.bus_ack) && k < 100) begin
      @(negedge clk); k++;
    end
    chk("reach_mem", {16'b0, bus_addr}, 32'h6004);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_bus_rd", {31'b0, bus_rd}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_outs", {reg_a_out, reg_f_out, reg_ip_out}, 32'd0);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || z80fi_valid) dcount++;
    end
    chk("rst_mid_no_done", dcount, 0);

    // randomized instructions
    for (int t = 0; t < 40; t++) begin
      p  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 1) ? 8'hDD : 8'hFD);
      o  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'h86 + 8 * $urandom_range(0, 7));
      d  = 8'($urandom);
      ip = 16'($urandom); ix = 16'($urandom); iy = 16'($urandom);
      place(ip, p, o, d);
      mem[op_addr(p, ix, iy, d)] = 8'($urandom);
      run_insn(ip, ix, iy, 8'($urandom), 8'($urandom), $urandom_range(0, 2), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
